// File: rtl/dm_cache_ctrl_if.sv
// dm_cache_ctrl_if: CPU-side request/response and memory-side req/ack bus
// for the direct-mapped cache controller.
interface dm_cache_ctrl_if #(
    parameter int DATA_W = 16
);
    // CPU side (driven by the address decoder / CPU)
    logic              cpu_req;
    logic              cpu_we;
    logic [27:0]       tag;
    logic [1:0]        line_id;
    logic [1:0]        word_id;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_busy;

    // Memory side
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // Cache controller view.
    modport slave (
        input  cpu_req, cpu_we, tag, line_id, word_id, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_busy,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    // Environment view: CPU/decoder plus memory.
    modport master (
        output cpu_req, cpu_we, tag, line_id, word_id, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_busy,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-through, no-write-allocate cache
// controller. 4 lines x 4 words x DATA_W, per-line tag and valid bit.
// Read misses refill the whole line over the req/ack memory port; every
// write is forwarded to memory, and only updates the array on a hit.
module dm_cache_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    dm_cache_ctrl_if.slave bus
);
    localparam int TAG_W = 28;
    localparam int LINES = 4;
    localparam int WORDS = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WRITE
    } state_t;

    state_t            state;

    // Request captured in IDLE and held for the whole transaction.
    logic [TAG_W-1:0]  tag_r;
    logic [1:0]        line_r;
    logic [1:0]        word_r;
    logic              we_r;
    logic [DATA_W-1:0] wdata_r;

    // Refill beat counter (word index of the beat in flight).
    logic [1:0]        cnt;

    // Cache state.
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [DATA_W-1:0] data_arr [LINES][WORDS];

    logic              hit;
    logic              ack;
    logic              wr_hit_en;
    logic              refill_en;
    logic              refill_done;

    // Hit detection and array write enables for the current cycle.
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        hit         = valid[line_r] && (tag_arr[line_r] == tag_r);
        ack         = bus.mem_ack && bus.mem_req;
        wr_hit_en   = (state == LOOKUP) && we_r && hit;
        refill_en   = (state == REFILL) && ack;
        refill_done = refill_en && (cnt == 2'd3);
    end

    // Data/tag storage: refill beats, write-hit updates, tag capture at refill end.
    // NOTE: storage has no reset; the valid bits alone decide whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (refill_en) begin
            data_arr[line_r][cnt] <= bus.mem_rdata;
        end else if (wr_hit_en) begin
            data_arr[line_r][word_r] <= wdata_r;
        end
        if (refill_done) begin
            tag_arr[line_r] <= tag_r;
        end
    end

    // Control FSM with registered CPU and memory outputs.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            valid         <= '0;
            cnt           <= '0;
            tag_r         <= '0;
            line_r        <= '0;
            word_r        <= '0;
            we_r          <= 1'b0;
            wdata_r       <= '0;
            bus.cpu_rdata <= '0;
            bus.cpu_ready <= 1'b0;
            bus.cpu_busy  <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.cpu_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        tag_r        <= bus.tag;
                        line_r       <= bus.line_id;
                        word_r       <= bus.word_id;
                        we_r         <= bus.cpu_we;
                        wdata_r      <= bus.cpu_wdata;
                        bus.cpu_busy <= 1'b1;
                        state        <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (we_r) begin
                        // Write-through: memory write regardless of hit.
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= {tag_r, line_r, word_r};
                        bus.mem_wdata <= wdata_r;
                        state         <= WRITE;
                    end else if (hit) begin
                        bus.cpu_rdata <= data_arr[line_r][word_r];
                        bus.cpu_ready <= 1'b1;
                        bus.cpu_busy  <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        // Line is invalid while it is being overwritten.
                        valid[line_r] <= 1'b0;
                        cnt           <= 2'd0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= {tag_r, line_r, 2'd0};
                        state         <= REFILL;
                    end
                end

                REFILL: begin
                    if (ack) begin
                        // Wraps 3 -> 0 only on the final beat.
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            valid[line_r] <= 1'b1;
                            bus.mem_req   <= 1'b0;
                            state         <= LOOKUP;
                        end else begin
                            bus.mem_addr <= {tag_r, line_r, cnt + 2'd1};
                        end
                    end
                end

                WRITE: begin
                    if (ack) begin
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.cpu_ready <= 1'b1;
                        bus.cpu_busy  <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed plus randomized test of dm_cache_ctrl against a
// behavioural cache/memory model kept in the bench.
`timescale 1ns/1ps
module tb_dm_cache_ctrl;
    localparam int DATA_W = 16;

    typedef struct {
        logic              we;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
        int                delay;
    } txn_t;

    logic clk;
    logic reset;

    dm_cache_ctrl_if #(.DATA_W(DATA_W)) bus ();

    dm_cache_ctrl #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the cache should hold, and the memory image.
    bit                m_valid [4];
    logic [27:0]       m_tag   [4];
    logic [DATA_W-1:0] m_data  [4][4];
    logic [DATA_W-1:0] mem_img [logic [31:0]];

    txn_t txq[$];
    int   force_delay = -1;
    int   ack_count   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_get(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return DATA_W'(a * 32'h9E37 + 32'h1234);
    endfunction

    // Memory responder: ack after 0..2 extra cycles, record every completed beat.
    initial begin : mem_responder
        int          wait_left;
        logic [31:0] cur_addr;
        logic        cur_we;
        logic [15:0] cur_wdata;
        int          cur_delay;
        wait_left     = -1;
        cur_addr      = '0;
        cur_we        = 1'b0;
        cur_wdata     = '0;
        cur_delay     = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = DATA_W'($urandom);
            if (reset) begin
                wait_left = -1;
            end else if (!bus.mem_req) begin
                wait_left   = -1;
                bus.mem_ack = ($urandom_range(0, 3) == 0);
            end else begin
                if (wait_left < 0) begin
                    cur_addr  = bus.mem_addr;
                    cur_we    = bus.mem_we;
                    cur_wdata = bus.mem_wdata;
                    cur_delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 2));
                    wait_left = cur_delay;
                end else begin
                    check("mem_addr_stable", bus.mem_addr, cur_addr);
                    check("mem_we_stable", bus.mem_we, cur_we);
                end
                if (wait_left == 0) begin
                    bus.mem_ack = 1'b1;
                    if (cur_we) mem_img[cur_addr] = cur_wdata;
                    else        bus.mem_rdata = mem_get(cur_addr);
                    txq.push_back('{cur_we, cur_addr, cur_wdata, cur_delay});
                    ack_count++;
                end
                wait_left--;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        check("rst_cpu_ready", bus.cpu_ready, 0);
        check("rst_cpu_busy",  bus.cpu_busy,  0);
        check("rst_mem_req",   bus.mem_req,   0);
        check("rst_mem_we",    bus.mem_we,    0);
        check("rst_mem_addr",  bus.mem_addr,  0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
    endtask

    // One CPU transaction, checked against the model, then the model is updated.
    task automatic do_op(input logic we, input logic [27:0] t, input logic [1:0] l,
                         input logic [1:0] w, input logic [DATA_W-1:0] wd);
        logic [31:0]       addr;
        bit                hit;
        bit                seen;
        int                cyc;
        int                exp_lat;
        logic [DATA_W-1:0] rdata;
        addr  = {t, l, w};
        hit   = m_valid[l] && (m_tag[l] == t);
        seen  = 1'b0;
        cyc   = 0;
        rdata = '0;
        txq.delete();
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.tag       = t;
        bus.line_id   = l;
        bus.word_id   = w;
        bus.cpu_wdata = wd;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.cpu_ready) begin
                seen  = 1'b1;
                rdata = bus.cpu_rdata;
            end else begin
                check("busy_while_pending", bus.cpu_busy, 1);
            end
        end
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'($urandom);
        bus.tag       = 28'($urandom);
        bus.cpu_wdata = DATA_W'($urandom);
        check("ready_seen", seen, 1);
        if (!seen) return;
        check("mem_req_low_at_ready", bus.mem_req, 0);
        @(negedge clk);
        check("ready_one_cycle", bus.cpu_ready, 0);
        check("idle_not_busy", bus.cpu_busy, 0);

        if (we) begin
            check("wr_beats", txq.size(), 1);
            if (txq.size() == 1) begin
                check("wr_is_write", txq[0].we, 1);
                check("wr_addr", txq[0].addr, addr);
                check("wr_data", txq[0].wdata, wd);
                exp_lat = 3 + txq[0].delay;
                check("wr_latency", cyc, exp_lat);
            end
            if (hit) m_data[l][w] = wd;
        end else if (hit) begin
            check("hit_no_mem", txq.size(), 0);
            check("hit_latency", cyc, 2);
            check("hit_rdata", rdata, m_data[l][w]);
        end else begin
            check("refill_beats", txq.size(), 4);
            exp_lat = 3;
            for (int k = 0; k < 4; k++) begin
                if (k < txq.size()) begin
                    check("refill_addr", txq[k].addr, {t, l, 2'(k)});
                    check("refill_is_read", txq[k].we, 0);
                    exp_lat += txq[k].delay + 1;
                end
                m_data[l][k] = mem_get({t, l, 2'(k)});
            end
            m_valid[l] = 1'b1;
            m_tag[l]   = t;
            check("miss_latency", cyc, exp_lat);
            check("miss_rdata", rdata, m_data[l][w]);
        end
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int cyc;
        reset         = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.tag       = '0;
        bus.line_id   = '0;
        bus.word_id   = '0;
        bus.cpu_wdata = '0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        // Directed plan: cold miss with known memory contents, then hit.
        mem_img[32'h18] = 16'hA0;
        mem_img[32'h19] = 16'hA1;
        mem_img[32'h1A] = 16'hA2;
        mem_img[32'h1B] = 16'hA3;
        do_op(1'b0, 28'h1, 2'd2, 2'd1, 16'h0);
        check("plan_miss_rdata", bus.cpu_rdata, 16'hA1);
        do_op(1'b0, 28'h1, 2'd2, 2'd1, 16'h0);

        // Write hit, then read back without refill.
        do_op(1'b1, 28'h1, 2'd2, 2'd1, 16'hBEEF);
        do_op(1'b0, 28'h1, 2'd2, 2'd1, 16'h0);
        check("plan_wr_readback", bus.cpu_rdata, 16'hBEEF);

        // Write miss: memory only; the read after it still refills.
        do_op(1'b1, 28'h2, 2'd0, 2'd3, 16'h1234);
        do_op(1'b0, 28'h2, 2'd0, 2'd3, 16'h0);
        check("plan_wr_miss_readback", bus.cpu_rdata, 16'h1234);

        // Conflict eviction on line 3.
        do_op(1'b0, 28'h1, 2'd3, 2'd0, 16'h0);
        do_op(1'b0, 28'h5, 2'd3, 2'd0, 16'h0);
        do_op(1'b0, 28'h1, 2'd3, 2'd0, 16'h0);

        // Reset after the second refill ack aborts the refill.
        force_delay = 1;
        base = ack_count;
        txq.delete();
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.tag       = 28'h7;
        bus.line_id   = 2'd1;
        bus.word_id   = 2'd2;
        cyc = 0;
        while ((ack_count - base) < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_two_acks", ack_count - base, 2);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        // Same address again: full refill with acks stretched to 3 cycles.
        force_delay = 2;
        do_op(1'b0, 28'h7, 2'd1, 2'd2, 16'h0);
        check("abort_refill_beats", txq.size(), 4);
        force_delay = -1;

        // Randomized traffic over a small tag set to force hits and conflicts.
        for (int n = 0; n < 150; n++) begin
            do_op(($urandom_range(0, 9) < 4), 28'($urandom_range(0, 3)),
                  2'($urandom), 2'($urandom), DATA_W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
